ysyx_24100029_gshare_btb: RTL and testbench

//  Upstream fetch-address predictor for the IFU. Each cycle it takes the current fetch PC
//  and returns the predicted next PC and a taken flag, both combinational.

---
 rtl/ysyx_24100029_gshare_btb.sv | 110 +++++++++++
 tb/tb_ysyx_24100029_gshare_btb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100029_gshare_btb.sv
// rtl/ysyx_24100029_gshare_btb.sv - direct-mapped BTB plus gshare PHT next-PC predictor
// Optional BPU_STATS_EN adds update/taken statistics counters.
module ysyx_24100029_gshare_btb #(
    parameter int BTB_ENTRIES = 16,
    parameter int PHT_ENTRIES = 64,
    parameter int BHR_WIDTH   = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] npc,
    output logic        pred_res,
    input  logic        br_valid,
    input  logic        br_is_taken,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_npc
`ifdef BPU_STATS_EN
    ,
    output logic [31:0] stat_upd,
    output logic [31:0] stat_taken
`endif
);

    localparam int IB    = $clog2(BTB_ENTRIES);
    localparam int IP    = $clog2(PHT_ENTRIES);
    localparam int TAG_W = 30 - IB;

    logic             btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
    logic [31:0]      btb_target [BTB_ENTRIES];
    logic [1:0]       pht        [PHT_ENTRIES];
    logic [BHR_WIDTH-1:0] bhr;
    logic [BHR_WIDTH-1:0] bhr_next;
    logic [IP-1:0]    bhr_ext;

    logic [IB-1:0]    l_bidx;
    logic [TAG_W-1:0] l_tag;
    logic [IP-1:0]    l_pidx;
    logic             l_hit;

    logic [IB-1:0]    u_bidx;
    logic [TAG_W-1:0] u_tag;
    logic [IP-1:0]    u_pidx;

    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, pc[1:0], br_pc[1:0]};

    assign bhr_ext = IP'(bhr);

    generate
        if (BHR_WIDTH == 1) begin : g_bhr_one
            assign bhr_next = br_is_taken;
        end else begin : g_bhr_shift
            assign bhr_next = {bhr[BHR_WIDTH-2:0], br_is_taken};
        end
    endgenerate

    // Lookup reads pre-update state only; no bypass from a same-cycle update.
    assign l_bidx   = pc[2 +: IB];
    assign l_tag    = pc[31:2+IB];
    assign l_pidx   = pc[2 +: IP] ^ bhr_ext;
    assign l_hit    = btb_valid[l_bidx] && (btb_tag[l_bidx] == l_tag);
    assign pred_res = l_hit && pht[l_pidx][1];
    assign npc      = pred_res ? btb_target[l_bidx] : pc + 32'd4;

    assign u_bidx = br_pc[2 +: IB];
    assign u_tag  = br_pc[31:2+IB];
    assign u_pidx = br_pc[2 +: IP] ^ bhr_ext;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
            end
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht[i] <= 2'b01;
            end
            bhr <= '0;
        end else if (br_valid) begin
            if (br_is_taken) begin
                if (pht[u_pidx] != 2'b11) begin
                    pht[u_pidx] <= pht[u_pidx] + 2'd1;
                end
                btb_valid[u_bidx]  <= 1'b1;
                btb_tag[u_bidx]    <= u_tag;
                btb_target[u_bidx] <= br_npc;
            end else if (pht[u_pidx] != 2'b00) begin
                pht[u_pidx] <= pht[u_pidx] - 2'd1;
            end
            bhr <= bhr_next;
        end
    end

`ifdef BPU_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_upd   <= '0;
            stat_taken <= '0;
        end else if (br_valid) begin
            stat_upd <= stat_upd + 32'd1;
            if (br_is_taken) begin
                stat_taken <= stat_taken + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_24100029_gshare_btb.sv
// tb/tb_ysyx_24100029_gshare_btb.sv - scoreboard bench for the gshare BTB predictor
module tb_ysyx_24100029_gshare_btb;

    logic        clock;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        pred_res;
    logic        br_valid;
    logic        br_is_taken;
    logic [31:0] br_pc;
    logic [31:0] br_npc;
`ifdef BPU_STATS_EN
    logic [31:0] stat_upd;
    logic [31:0] stat_taken;
`endif

    ysyx_24100029_gshare_btb dut (
        .clock       (clock),
        .reset       (reset),
        .pc          (pc),
        .npc         (npc),
        .pred_res    (pred_res),
        .br_valid    (br_valid),
        .br_is_taken (br_is_taken),
        .br_pc       (br_pc),
        .br_npc      (br_npc)
`ifdef BPU_STATS_EN
        ,
        .stat_upd    (stat_upd),
        .stat_taken  (stat_taken)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model for the default 16/64/3 configuration.
    logic        m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    logic [1:0]  m_pht   [64];
    logic [2:0]  m_bhr;

    logic [32:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
        end
        for (int i = 0; i < 64; i++) m_pht[i] = 2'b01;
        m_bhr = 3'b000;
    endtask

    function automatic logic [32:0] m_predict(input logic [31:0] a);
        logic [3:0] b;
        logic [5:0] p;
        logic       t;
        b = a[5:2];
        p = a[7:2] ^ {3'b000, m_bhr};
        t = m_valid[b] && (m_tag[b] == a[31:6]) && m_pht[p][1];
        return {t, t ? m_tgt[b] : a + 32'd4};
    endfunction

    task automatic m_update(input logic [31:0] a, input logic t, input logic [31:0] tg);
        logic [5:0] p;
        p = a[7:2] ^ {3'b000, m_bhr};
        if (t) begin
            if (m_pht[p] != 2'b11) m_pht[p] = m_pht[p] + 2'd1;
            m_valid[a[5:2]] = 1'b1;
            m_tag[a[5:2]]   = a[31:6];
            m_tgt[a[5:2]]   = tg;
        end else if (m_pht[p] != 2'b00) begin
            m_pht[p] = m_pht[p] - 2'd1;
        end
        m_bhr = {m_bhr[1:0], t};
    endtask

    task automatic compare(input string tg);
        logic [32:0] e;
        e = sb_q.pop_front();
        check({tg, "_npc"}, npc, e[31:0]);
        check({tg, "_pred"}, 32'(pred_res), 32'(e[32]));
    endtask

    task automatic lookup(input string tg, input logic [31:0] a);
        @(negedge clock);
        pc = a;
        sb_q.push_back(m_predict(a));
        #1;
        compare(tg);
    endtask

    task automatic update(input logic [31:0] a, input logic t, input logic [31:0] tg);
        @(negedge clock);
        br_valid    = 1'b1;
        br_pc       = a;
        br_is_taken = t;
        br_npc      = t ? tg : $urandom;
        @(posedge clock);
        m_update(a, t, tg);
        #1;
        br_valid    = 1'b0;
        br_is_taken = $urandom_range(0, 1);
        br_npc      = $urandom;
    endtask

    logic [31:0] rnd_pcs [4];

    initial begin
        reset       = 1'b0;
        pc          = 32'h30000000;
        br_valid    = 1'b0;
        br_is_taken = 1'b0;
        br_pc       = '0;
        br_npc      = '0;
        m_reset();
        rnd_pcs[0] = 32'h30000010;
        rnd_pcs[1] = 32'h30000050;
        rnd_pcs[2] = 32'h30000020;
        rnd_pcs[3] = 32'h3000FF04;

        #12;
        check("rst_hold_npc", npc, 32'h30000004);
        check("rst_hold_pred", 32'(pred_res), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        lookup("t1", 32'h30000000);
        check("t1_const", npc, 32'h30000004);
        for (int i = 0; i < 4; i++) lookup("t1_any", $urandom);

        for (int i = 0; i < 3; i++) update(32'h30000010, 1'b1, 32'h30000100);
        lookup("t2_weak", 32'h30000010);
        check("t2_weak_const", npc, 32'h30000014);
        update(32'h30000010, 1'b1, 32'h30000100);
        lookup("t2_taken", 32'h30000010);
        check("t2_taken_const", npc, 32'h30000100);
        check("t2_taken_pred", 32'(pred_res), 32'd1);

        lookup("t3_alias", 32'h30000050);
        check("t3_alias_const", npc, 32'h30000054);

        for (int i = 0; i < 8; i++) update(32'h30000010, 1'b1, 32'h30000100);
        lookup("t4_sat", 32'h30000010);
        update(32'h30000010, 1'b1, 32'h30000100);
        lookup("t4_sat9", 32'h30000010);
        update(32'h30000010, 1'b0, 32'h0);
        lookup("t4_nt", 32'h30000010);
        check("t4_nt_const", npc, 32'h30000014);
        for (int i = 0; i < 3; i++) update(32'h30000020, 1'b1, 32'h30000200);
        lookup("t4_ctr10", 32'h30000010);
        check("t4_ctr10_const", npc, 32'h30000100);

        lookup("t5_wrap", 32'hFFFFFFFC);
        check("t5_wrap_const", npc, 32'h00000000);

        // Same-cycle lookup and update at one index.
        @(negedge clock);
        pc          = 32'h30000010;
        br_valid    = 1'b1;
        br_pc       = 32'h30000010;
        br_is_taken = 1'b0;
        br_npc      = 32'h0;
        sb_q.push_back(m_predict(pc));
        #1;
        compare("t5_same_old");
        check("t5_same_old_const", npc, 32'h30000100);
        @(posedge clock);
        m_update(32'h30000010, 1'b0, 32'h0);
        #1;
        br_valid = 1'b0;
        sb_q.push_back(m_predict(pc));
        compare("t5_same_new");
        check("t5_same_new_const", npc, 32'h30000014);

        for (int i = 0; i < 60; i++) begin
            update(rnd_pcs[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                   {$urandom_range(0, 32'hFFFF), 2'b00} | 32'h40000000);
            lookup("rnd", rnd_pcs[$urandom_range(0, 3)]);
        end

        for (int i = 0; i < 4; i++) update(32'h30000010, 1'b1, 32'h30000100);
        lookup("t6_pre", 32'h30000010);
        check("t6_pre_const", npc, 32'h30000100);
        @(negedge clock);
        #1 reset = 1'b0;
        #1;
        check("t6_async_npc", npc, 32'h30000014);
        check("t6_async_pred", 32'(pred_res), 32'd0);
        m_reset();
        #1 reset = 1'b1;
        lookup("t6_post", 32'h30000010);

`ifdef BPU_STATS_EN
        update(32'h30000010, 1'b1, 32'h30000100);
        update(32'h30000014, 1'b0, 32'h0);
        update(32'h30000018, 1'b1, 32'h30000300);
        update(32'h3000001C, 1'b0, 32'h0);
        update(32'h30000020, 1'b1, 32'h30000400);
        check("t6_stat_upd", stat_upd, 32'd5);
        check("t6_stat_taken", stat_taken, 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
